mem_port_arbiter: RTL and testbench

Arbitrates the data memory's single read/write port between the instruction-fetch requester and the load/store requester. It accepts byte-addressed requests over a req/gnt handshake and converts them to word addresses. It drives the memory's RW port and returns registered read data or write acknowledges one cycle after grant. It sits between the CPU datapath and the memory register array.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_rr.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the data-memory port arbiter
package mem_arb_pkg;

  // Which requester won the most recent grant
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_win_e;

  // Byte-to-word shift: memory words are 4 bytes
  localparam int WORD_LSB = 2;

  // Byte-offset bits that must be zero for a word-aligned access
  localparam logic [WORD_LSB-1:0] ALIGN_MASK = 2'b11;

  // True when the byte offset selects the first byte of a word
  function automatic logic is_aligned(input logic [WORD_LSB-1:0] byte_off);
    return (byte_off & ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// rtl/mem_arb_rr.sv - two-input grant selector; policy chosen by MEM_ARB_ROUND_ROBIN_EN
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic      en,
  input  logic      i_req,
  input  logic      d_req,
  input  last_win_e last_win,
  output logic      i_gnt,
  output logic      d_gnt
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On conflict the requester that did not win last time is served
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (en) begin
      if (i_req && d_req) begin
        i_gnt = (last_win == LAST_D);
        d_gnt = (last_win == LAST_I);
      end else begin
        i_gnt = i_req;
        d_gnt = d_req;
      end
    end
  end
`else
  // Load/store always beats fetch; history is irrelevant to selection here
  logic unused_last_win;
  assign unused_last_win = (last_win == LAST_D);

  // Fixed priority: load/store first, fetch only when load/store is idle
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (en) begin
      d_gnt = d_req;
      i_gnt = i_req && !d_req;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the data memory RW port between fetch and load/store (MEM_ARB_ROUND_ROBIN_EN selects round-robin)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_ADDR_W = 30,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  output logic                  i_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  last_win_e last_win;
  last_win_e last_win_nxt;
  logic      i_aligned;
  logic      d_aligned;

  assign i_aligned = is_aligned(i_addr[WORD_LSB-1:0]);
  assign d_aligned = is_aligned(d_addr[WORD_LSB-1:0]);

  // Grants are forced low while reset is held so nothing reaches memory
  mem_arb_rr u_arb (
    .en       (reset_n),
    .i_req    (i_req),
    .d_req    (d_req),
    .last_win (last_win),
    .i_gnt    (i_gnt),
    .d_gnt    (d_gnt)
  );

  // Arbitration history register; load/store counts as last winner out of reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_win <= LAST_D;
    end else begin
      last_win <= last_win_nxt;
    end
  end

  // History follows the winner of each grant and holds when nobody is granted
  always_comb begin
    last_win_nxt = last_win;
    if (d_gnt) begin
      last_win_nxt = LAST_D;
    end else if (i_gnt) begin
      last_win_nxt = LAST_I;
    end
  end

  // Memory port mux; when idle the address tracks the previous winner's channel
  always_comb begin
    mem_wdata = d_wdata;
    mem_we    = d_gnt && d_we && d_aligned;
    if (d_gnt) begin
      mem_addr = d_addr[ADDR_W-1:WORD_LSB];
    end else if (i_gnt) begin
      mem_addr = i_addr[ADDR_W-1:WORD_LSB];
    end else if (last_win == LAST_D) begin
      mem_addr = d_addr[ADDR_W-1:WORD_LSB];
    end else begin
      mem_addr = i_addr[ADDR_W-1:WORD_LSB];
    end
  end

  // Fetch response: one rvalid pulse per grant, data/err held between grants
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      i_err    <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      if (i_gnt) begin
        i_err   <= !i_aligned;
        i_rdata <= i_aligned ? mem_rdata : '0;
      end
    end
  end

  // Load/store response: stores and misaligned accesses return zero data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      d_rvalid <= d_gnt;
      if (d_gnt) begin
        d_err   <= !d_aligned;
        d_rdata <= (d_aligned && !d_we) ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [29:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  // memory array seen by the DUT, and the model's own copy
  logic [31:0] mem [64];
  logic [31:0] model_mem [64];

  // model state
  bit          m_last_d;
  bit          exp_i_rvalid, exp_i_err, exp_d_rvalid, exp_d_err;
  logic [31:0] exp_i_rdata, exp_d_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = (mem_addr < 30'd64) ? mem[mem_addr[5:0]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    if (mem_we && mem_addr < 30'd64) mem[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_resp();
    chk("i_rvalid", {31'd0, i_rvalid}, {31'd0, exp_i_rvalid});
    chk("i_rdata", i_rdata, exp_i_rdata);
    chk("i_err", {31'd0, i_err}, {31'd0, exp_i_err});
    chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, exp_d_rvalid});
    chk("d_rdata", d_rdata, exp_d_rdata);
    chk("d_err", {31'd0, d_err}, {31'd0, exp_d_err});
  endtask

  task automatic model_reset();
    m_last_d     = 1'b1;
    exp_i_rvalid = 1'b0;
    exp_i_rdata  = '0;
    exp_i_err    = 1'b0;
    exp_d_rvalid = 1'b0;
    exp_d_rdata  = '0;
    exp_d_err    = 1'b0;
  endtask

  // One bus cycle: check last responses, drive requests, check the combinational
  // port against the model, then advance the model to the following cycle.
  task automatic cycle(input bit ir, input logic [31:0] ia, input bit dr, input bit dwe,
                       input logic [31:0] da, input logic [31:0] dw,
                       output bit ig, output bit dg);
    bit i_al, d_al;
    @(negedge clk);
    check_resp();
    i_req = ir; i_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dw;
    #1;
    if (ir && dr) begin
      ig = RR ? m_last_d : 1'b0;
      dg = !ig;
    end else begin
      ig = ir;
      dg = dr;
    end
    i_al = (ia % 4) == 0;
    d_al = (da % 4) == 0;
    chk("i_gnt", {31'd0, i_gnt}, {31'd0, ig});
    chk("d_gnt", {31'd0, d_gnt}, {31'd0, dg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, dg && dwe && d_al});
    if (dg) begin
      chk("mem_addr_d", {2'b0, mem_addr}, da / 4);
      chk("mem_wdata", mem_wdata, dw);
    end else if (ig) begin
      chk("mem_addr_i", {2'b0, mem_addr}, ia / 4);
    end
    exp_i_rvalid = ig;
    if (ig) begin
      exp_i_err   = !i_al;
      exp_i_rdata = i_al ? model_mem[ia / 4] : 32'd0;
    end
    exp_d_rvalid = dg;
    if (dg) begin
      exp_d_err   = !d_al;
      exp_d_rdata = (d_al && !dwe) ? model_mem[da / 4] : 32'd0;
      if (d_al && dwe) model_mem[da / 4] = dw;
    end
    if (dg) m_last_d = 1'b1;
    else if (ig) m_last_d = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom_range(0, 63) * 4;
    if ($urandom_range(0, 7) == 0) a = a + $urandom_range(1, 3);
    return a;
  endfunction

  initial begin
    bit ig, dg;
    bit ip, dp, dwe_r;
    logic [31:0] ia_r, da_r, dw_r;

    for (int k = 0; k < 64; k++) begin
      mem[k] = $urandom;
      model_mem[k] = mem[k];
    end
    mem[4] = 32'hDEADBEEF;
    model_mem[4] = 32'hDEADBEEF;
    model_reset();

    // reset state with both requesters asking
    reset_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h1;
    #2;
    chk("rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_resp();
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // fetch alone at 0x10
    cycle(1, 32'h10, 0, 0, 0, 0, ig, dg);
    chk("fetch_gnt", {31'd0, i_gnt}, 32'd1);
    tick();
    chk("fetch_rvalid", {31'd0, i_rvalid}, 32'd1);
    chk("fetch_rdata", i_rdata, 32'hDEADBEEF);
    chk("fetch_err", {31'd0, i_err}, 32'd0);
    chk("fetch_d_rvalid", {31'd0, d_rvalid}, 32'd0);

    // store then load of the same word
    cycle(0, 0, 1, 1, 32'h20, 32'h12345678, ig, dg);
    chk("store_mem_we", {31'd0, mem_we}, 32'd1);
    chk("store_mem_addr", {2'b0, mem_addr}, 32'd8);
    cycle(0, 0, 1, 0, 32'h20, 32'h0, ig, dg);
    chk("store_ack_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("store_ack_rdata", d_rdata, 32'd0);
    tick();
    chk("load_after_store", d_rdata, 32'h12345678);

    // continuous conflict for four cycles
    for (int k = 0; k < 4; k++) begin
      cycle(1, 32'h40 + 4 * k, 1, 0, 32'h80 + 4 * k, 0, ig, dg);
      chk("conflict_i_gnt", {31'd0, i_gnt}, {31'd0, RR && (k % 2 == 0)});
      chk("conflict_d_gnt", {31'd0, d_gnt}, {31'd0, !(RR && (k % 2 == 0))});
    end

    // misaligned load, then misaligned store that must not write
    cycle(0, 0, 1, 0, 32'h21, 0, ig, dg);
    chk("mis_load_gnt", {31'd0, d_gnt}, 32'd1);
    chk("mis_load_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("mis_load_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("mis_load_err", {31'd0, d_err}, 32'd1);
    chk("mis_load_rdata", d_rdata, 32'd0);
    cycle(0, 0, 1, 1, 32'h21, 32'hAAAA5555, ig, dg);
    chk("mis_store_we", {31'd0, mem_we}, 32'd0);
    tick();
    chk("mis_store_err", {31'd0, d_err}, 32'd1);
    chk("mis_store_mem", mem[8], 32'h12345678);

    // reset asserted right after a fetch grant is seen
    cycle(1, 32'h14, 0, 0, 0, 0, ig, dg);
    #1;
    reset_n = 1'b0;
    d_req = 1'b1;
    #1;
    model_reset();
    chk("mid_rst_i_gnt", {31'd0, i_gnt}, 32'd0);
    chk("mid_rst_d_gnt", {31'd0, d_gnt}, 32'd0);
    chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_i_rdata", i_rdata, 32'd0);
    chk("mid_rst_d_err", {31'd0, d_err}, 32'd0);
    repeat (2) begin
      tick();
      chk("mid_rst_i_rvalid", {31'd0, i_rvalid}, 32'd0);
      chk("mid_rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    end
    @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    reset_n = 1'b1;
    cycle(1, 32'h18, 1, 0, 32'h1C, 0, ig, dg);
    chk("post_rst_i_gnt", {31'd0, i_gnt}, {31'd0, RR});
    tick();
    chk("post_rst_i_rvalid", {31'd0, i_rvalid}, {31'd0, RR});

    // randomized traffic obeying the hold-until-grant rule
    ip = 0; dp = 0; dwe_r = 0; ia_r = 0; da_r = 0; dw_r = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!ip && $urandom_range(0, 3) != 0) begin
        ip = 1; ia_r = rand_addr();
      end
      if (!dp && $urandom_range(0, 3) != 0) begin
        dp = 1; da_r = rand_addr(); dwe_r = $urandom_range(0, 1); dw_r = $urandom;
      end
      cycle(ip, ia_r, dp, dwe_r, da_r, dw_r, ig, dg);
      if (ig) ip = 0;
      if (dg) dp = 0;
    end
    cycle(0, 0, 0, 0, 0, 0, ig, dg);
    @(negedge clk);
    check_resp();
    for (int k = 0; k < 64; k++) chk("final_mem", mem[k], model_mem[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
